// File: rtl/best_sad_accumulator_if.sv
// best_sad_accumulator_if: search control/result bundle; master drives start and cicle results, slave returns status and result
interface best_sad_accumulator_if #(
  parameter int SAD_WIDTH = 16,
  parameter int IDX_WIDTH = 8
);
  logic                 start;
  logic                 sad_valid;
  logic [SAD_WIDTH-1:0] best_sad_cicle;
  logic [2:0]           address_best_sad_cicle;
  logic                 busy;
  logic                 done;
  logic [SAD_WIDTH-1:0] best_sad;
  logic [IDX_WIDTH-1:0] best_index;
  logic                 addr_err;
  modport master (
    output start, sad_valid, best_sad_cicle, address_best_sad_cicle,
    input  busy, done, best_sad, best_index, addr_err
  );
  modport slave (
    input  start, sad_valid, best_sad_cicle, address_best_sad_cicle,
    output busy, done, best_sad, best_index, addr_err
  );
endinterface

// File: rtl/best_sad_accumulator.sv
// best_sad_accumulator: running minimum of per-cicle best SADs over one search; ports clk, rst_n (async low), bus (slave: start/sad_valid/best_sad_cicle/address_best_sad_cicle in; busy/done/best_sad/best_index/addr_err out); optional ZERO_SAD_EXIT_EN ends the search on an accepted zero SAD
module best_sad_accumulator #(
  parameter int SAD_WIDTH  = 16,
  parameter int NUM_CICLES = 8,
  parameter int IDX_WIDTH  = 8
) (
  input logic clk,
  input logic rst_n,
  best_sad_accumulator_if.slave bus
);
  localparam int CW = $clog2(NUM_CICLES) + 1;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t               state_q, state_d;
  logic [SAD_WIDTH-1:0] run_min_q, run_min_d, best_sad_q, best_sad_d;
  logic [IDX_WIDTH-1:0] run_idx_q, run_idx_d, best_idx_q, best_idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 addr_ok, upd, fin;
  logic [SAD_WIDTH-1:0] new_min;
  logic [IDX_WIDTH-1:0] cand_idx, new_idx;
  assign addr_ok  = bus.address_best_sad_cicle <= 3'd5;
  assign cand_idx = IDX_WIDTH'(cnt_q) * IDX_WIDTH'(6) + IDX_WIDTH'(bus.address_best_sad_cicle);
  assign upd      = addr_ok && (bus.best_sad_cicle < run_min_q);
  assign new_min  = upd ? bus.best_sad_cicle : run_min_q;
  assign new_idx  = upd ? cand_idx : run_idx_q;
`ifdef ZERO_SAD_EXIT_EN
  assign fin = (cnt_q == CW'(NUM_CICLES - 1)) || (addr_ok && bus.best_sad_cicle == '0);
`else
  assign fin = cnt_q == CW'(NUM_CICLES - 1);
`endif
  always_comb begin
    state_d    = state_q;
    run_min_d  = run_min_q;
    run_idx_d  = run_idx_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d   = ACCUM;
        run_min_d = '1;
        run_idx_d = '0;
        cnt_d     = '0;
        err_d     = 1'b0;
      end
      ACCUM: if (bus.sad_valid) begin
        run_min_d = new_min;
        run_idx_d = new_idx;
        cnt_d     = cnt_q + 1'b1;
        err_d     = err_q | ~addr_ok;
        if (fin) begin
          state_d    = DONE;
          best_sad_d = new_min;
          best_idx_d = new_idx;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      run_min_q  <= '0;
      run_idx_q  <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      best_sad_q <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      run_min_q  <= run_min_d;
      run_idx_q  <= run_idx_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
    end
  end
  assign bus.busy       = state_q == ACCUM;
  assign bus.done       = state_q == DONE;
  assign bus.best_sad   = best_sad_q;
  assign bus.best_index = best_idx_q;
  assign bus.addr_err   = err_q;
endmodule

// File: tb/tb_best_sad_accumulator.sv
// tb_best_sad_accumulator: randomized and directed searches checked against a list-based minimum model
module tb_best_sad_accumulator;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int fails = 0;
  logic [15:0] sads [N];
  logic [2:0]  addrs [N];
  best_sad_accumulator_if #(.SAD_WIDTH(16), .IDX_WIDTH(8)) bus ();
  best_sad_accumulator #(.SAD_WIDTH(16), .NUM_CICLES(N), .IDX_WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic model(output logic [15:0] ms, output logic [7:0] mi, output int used, output bit me);
    ms = 16'hFFFF;
    mi = 0;
    me = 0;
    used = N;
    for (int i = 0; i < N; i++) begin
      if (addrs[i] > 5) me = 1;
      else begin
        if (sads[i] < ms) begin
          ms = sads[i];
          mi = 8'(i * 6 + int'(addrs[i]));
        end
`ifdef ZERO_SAD_EXIT_EN
        if (sads[i] == 0) begin
          used = i + 1;
          break;
        end
`endif
      end
    end
  endtask
  task automatic run_search(input int gapmax, input bit midstart);
    logic [15:0] ms;
    logic [7:0]  mi;
    int used;
    bit me;
    model(ms, mi, used, me);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 1);
    check("err_cleared", 32'(bus.addr_err), 0);
    for (int i = 0; i < N; i++) begin
      int g = gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0;
      for (int k = 0; k < g; k++) begin
        bus.start = midstart && i < used ? 1'($urandom_range(0, 1)) : 1'b0;
        cyc();
        bus.start = 1'b0;
        check("done_in_gap", 32'(bus.done), 0);
      end
      bus.sad_valid = 1'b1;
      bus.best_sad_cicle = sads[i];
      bus.address_best_sad_cicle = addrs[i];
      cyc();
      bus.sad_valid = 1'b0;
      if (i == used - 1) begin
        check("done_pulse", 32'(bus.done), 1);
        check("busy_in_done", 32'(bus.busy), 0);
        check("best_sad", 32'(bus.best_sad), 32'(ms));
        check("best_index", 32'(bus.best_index), 32'(mi));
        check("addr_err", 32'(bus.addr_err), 32'(me));
      end else if (i < used - 1) begin
        check("no_early_done", 32'(bus.done), 0);
        check("busy_accum", 32'(bus.busy), 1);
      end else begin
        check("idle_ignores_valid", 32'(bus.done | bus.busy), 0);
      end
    end
    cyc();
    check("done_one_clock", 32'(bus.done), 0);
    check("held_sad", 32'(bus.best_sad), 32'(ms));
    check("held_index", 32'(bus.best_index), 32'(mi));
  endtask
  initial begin
    bus.start = 1'b0;
    bus.sad_valid = 1'b0;
    bus.best_sad_cicle = '0;
    bus.address_best_sad_cicle = '0;
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_sad", 32'(bus.best_sad), 0);
    check("rst_index", 32'(bus.best_index), 0);
    check("rst_err", 32'(bus.addr_err), 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    sads  = '{900, 800, 700, 650, 700, 900, 999, 999};
    addrs = '{0, 1, 2, 3, 4, 5, 0, 1};
    run_search(0, 0);
    check("t2_index_21", 32'(bus.best_index), 21);
    sads  = '{500, 800, 800, 800, 800, 500, 800, 800};
    addrs = '{2, 0, 1, 3, 4, 4, 5, 0};
    run_search(0, 0);
    check("t3_tie_earlier", 32'(bus.best_index), 2);
    sads  = '{120, 300, 1, 100, 450, 200, 110, 999};
    addrs = '{1, 0, 7, 5, 2, 3, 4, 0};
    run_search(0, 0);
    check("t5_err", 32'(bus.addr_err), 1);
    sads  = '{500, 0, 300, 200, 400, 600, 700, 800};
    addrs = '{0, 5, 1, 2, 3, 4, 5, 0};
    run_search(0, 0);
    check("t6_index_11", 32'(bus.best_index), 11);
    sads  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    addrs = '{3, 4, 5, 0, 1, 2, 3, 4};
    run_search(2, 1);
    check("allones_sad", 32'(bus.best_sad), 32'hFFFF);
    sads  = '{900, 800, 700, 650, 700, 900, 999, 999};
    addrs = '{0, 1, 2, 3, 4, 5, 0, 1};
    run_search(4, 1);
    check("t4_gapped_index", 32'(bus.best_index), 21);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.sad_valid = 1'b1;
      bus.best_sad_cicle = 16'(10 + i);
      bus.address_best_sad_cicle = 3'd7;
      cyc();
    end
    bus.sad_valid = 1'b0;
    check("pre_rst_err", 32'(bus.addr_err), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_sad", 32'(bus.best_sad), 0);
    check("mid_rst_index", 32'(bus.best_index), 0);
    check("mid_rst_err", 32'(bus.addr_err), 0);
    cyc();
    check("rst_no_done", 32'(bus.done), 0);
    rst_n = 1'b1;
    cyc();
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) begin
        int sel = int'($urandom_range(0, 9));
        sads[i]  = sel == 0 ? 16'd0 : sel < 4 ? 16'($urandom_range(1, 20)) : 16'($urandom);
        addrs[i] = $urandom_range(0, 7) == 7 ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      end
      run_search(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
